// File: rtl/pcie_tlp_pkg.sv
// Shared TLP constants, generator state encoding and the MWr header builder.
package pcie_tlp_pkg;

    localparam logic [1:0] FMT_3DW_DATA = 2'b10;
    localparam logic [1:0] FMT_4DW_DATA = 2'b11;
    localparam logic [4:0] TYPE_MEM     = 5'b00000;

    typedef enum logic [2:0] {IDLE, REQ, BEAT0, BEAT1, BEAT2, REL} state_t;

    // h1 in the upper half so the struct drops straight onto beat 0
    typedef struct packed {
        logic [31:0] h1;
        logic [31:0] h0;
    } mwr_hdr_t;

    function automatic mwr_hdr_t build_mwr_hdr(input logic        is64,
                                               input logic [15:0] req_id,
                                               input logic [7:0]  tag);
        mwr_hdr_t hdr;
        hdr.h0 = {1'b0, (is64 ? FMT_4DW_DATA : FMT_3DW_DATA), TYPE_MEM, 1'b0, 3'b000,
                  4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 10'd1};
        hdr.h1 = {req_id, tag, 4'h0, 4'hF};
        return hdr;
    endfunction

endpackage

// File: rtl/pcie_mwr_tlp_gen_if.sv
// TX side of the generator: arbiter req/ack plus the 64-bit AXI4-Stream beat.
interface pcie_mwr_tlp_gen_if #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
);
    logic                    req;
    logic                    ack;
    logic                    tready;
    logic [C_DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0]   tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    src_dsc;

    modport master (output req, tdata, tkeep, tlast, tvalid, src_dsc,
                    input  ack, tready);
    modport slave  (input  req, tdata, tkeep, tlast, tvalid, src_dsc,
                    output ack, tready);
endinterface

// File: rtl/pcie_mwr_tlp_gen.sv
// Single-DW Memory Write TLP generator: accepts a command, wins the arbiter,
// then streams a 3DW or 4DW MWr TLP with full tready backpressure.
module pcie_mwr_tlp_gen
    import pcie_tlp_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int TCQ          = 1
) (
    input  logic                clk,
    input  logic                sys_rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [63:0]         cmd_addr,
    input  logic [31:0]         cmd_data,
    input  logic [15:0]         cfg_completer_id,
    pcie_mwr_tlp_gen_if.master  tx,
    output logic [31:0]         tlp_count
);

    if (C_DATA_WIDTH != 64 || KEEP_WIDTH != C_DATA_WIDTH / 8 || TCQ < 0) begin : g_bad_param
        $error("pcie_mwr_tlp_gen: only a 64-bit stream is supported");
    end

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    req_q, req_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [C_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
    logic [7:0]              tag_q, tag_d;
    logic [31:0]             count_q, count_d;
    logic [63:2]             addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic [15:0]             id_q, id_d;
    logic                    is64_q, is64_d;
    logic                    beat_hs;
    logic                    pkt_done;
    logic                    unused_addr_lo;

    // DW alignment makes the low address bits meaningless
    assign unused_addr_lo = ^cmd_addr[1:0];
    assign beat_hs        = tvalid_q && tx.tready;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        req_d       = req_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tag_d       = tag_q;
        count_d     = count_q;
        addr_d      = addr_q;
        data_d      = data_q;
        id_d        = id_q;
        is64_d      = is64_q;
        pkt_done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_ready_q && cmd_valid) begin
                    addr_d      = cmd_addr[63:2];
                    data_d      = cmd_data;
                    id_d        = cfg_completer_id;
                    is64_d      = |cmd_addr[63:32];
                    cmd_ready_d = 1'b0;
                    req_d       = 1'b1;
                    state_d     = REQ;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            REQ: begin
                if (tx.ack) begin
                    state_d  = BEAT0;
                    tvalid_d = 1'b1;
                    tdata_d  = build_mwr_hdr(is64_q, id_q, tag_q);
                    tkeep_d  = '1;
                    tlast_d  = 1'b0;
                end
            end
            BEAT0: begin
                if (beat_hs) begin
                    state_d = BEAT1;
                    tdata_d = is64_q ? {addr_q[31:2], 2'b00, addr_q[63:32]}
                                     : {data_q, addr_q[31:2], 2'b00};
                    tlast_d = !is64_q;
                end
            end
            BEAT1: begin
                if (beat_hs) begin
                    if (is64_q) begin
                        state_d = BEAT2;
                        tdata_d = {32'h0, data_q};
                        tkeep_d = 8'h0F;
                        tlast_d = 1'b1;
                    end else begin
                        pkt_done = 1'b1;
                    end
                end
            end
            BEAT2: pkt_done = beat_hs;
            REL: begin
                // a stale grant must be gone before the next command can win again
                if (!tx.ack) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pkt_done) begin
            state_d  = REL;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            req_d    = 1'b0;
            tag_d    = tag_q + 8'd1;
            count_d  = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            req_q       <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tag_q       <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            id_q        <= '0;
            is64_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            req_q       <= req_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tag_q       <= tag_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            id_q        <= id_d;
            is64_q      <= is64_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign tx.req     = req_q;
    assign tx.tvalid  = tvalid_q;
    assign tx.tlast   = tlast_q;
    assign tx.tdata   = tdata_q;
    assign tx.tkeep   = tkeep_q;
    assign tx.src_dsc = 1'b0;
    assign tlp_count  = count_q;

endmodule

// File: doc/pcie_mwr_tlp_gen.md
Name: pcie_mwr_tlp_gen

Overview:
- Upstream producer for the PCIe TX arbiter.
- Accepts single-DW memory-write commands and builds PCIe Memory Write TLPs. Uses the 3DW header for 32-bit addresses and the 4DW header for 64-bit addresses.
- Wins the TX path through the arbiter's req/ack handshake, then streams the TLP on a 64-bit AXI4-Stream interface with full tready backpressure.
- Its output connects one-to-one to one arbiter input port: req, ack, tready, tdata, tkeep, tlast, tvalid, src_dsc.

Parameters:
- C_DATA_WIDTH, 64, AXIS data width; only 64 is supported.
- KEEP_WIDTH, C_DATA_WIDTH/8, tkeep width.
- TCQ, 1, clock-to-out delay used in simulation.

Ports:
- clk  in  1  core user clock.
- sys_rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  write command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  64  byte address; bits [1:0] are ignored.
- cmd_data  in  32  write payload DW.
- cfg_completer_id  in  16  requester ID {bus, dev, func}.
- tx_req  out  1  request to the arbiter.
- tx_ack  in  1  grant from the arbiter.
- tx_tready  in  1  AXIS ready, passed through from the arbiter.
- tx_tdata  out  64  AXIS data.
- tx_tkeep  out  8  AXIS byte enables.
- tx_tlast  out  1  AXIS end of packet.
- tx_tvalid  out  1  AXIS valid.
- tx_src_dsc  out  1  source discontinue; tied to 0.
- tlp_count  out  32  number of TLPs fully sent; wraps.

Behaviour:
- Reset (sys_rst_n==0 at posedge): state=IDLE; cmd_ready, tx_req, tx_tvalid, tx_tlast=0; tx_tdata=0; tx_tkeep=0; tag=0; tlp_count=0. Any TLP in progress is abandoned. tx_req drops on the same edge. The arbiter sees req low and releases its grant.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr/data, compute is64 = |cmd_addr[63:32], and drive cmd_ready=0.
  - Next state REQ with tx_req=1.
- REQ: hold tx_req=1 until tx_ack==1, then go to BEAT0 and present beat 0 with tx_tvalid=1.
- Header fields:
  - H0 = {1'b0, fmt = is64 ? 2'b11 : 2'b10, type 5'b00000, 1'b0, TC 3'b000, 4'b0, TD 0, EP 0, attr 2'b00, 2'b00, length 10'd1}.
  - H1 = {cfg_completer_id, tag[7:0], lastBE 4'h0, firstBE 4'hF}.
- Beat layout: DW0 sits in tdata[31:0], DW1 in tdata[63:32].
  - 3DW TLP: beat0 = {H1, H0}, keep FF. beat1 = {data, addr[31:2], 2'b00}, keep FF, tlast=1.
  - 4DW TLP: beat0 = {H1, H0}. beat1 = {addr[31:2], 2'b00, addr[63:32]}, keep FF. beat2 = {32'h0, data}, keep 0F, tlast=1.
- Beat advance: a beat advances only on tx_tvalid && tx_tready. tdata, tkeep and tlast are held stable while tready==0. tvalid is never dropped mid-packet.
- On the tlast handshake:
  - tx_tvalid=0, tx_req=0, tag increments (mod 256), tlp_count increments (mod 2^32).
  - Next state REL.
- REL: wait for tx_ack==0, then go to IDLE (cmd_ready=1 next cycle).
- Command throughput: minimum cycle count per command, with tready=1 and immediate grant, is 1 accept + 1 REQ + beats + 1 REL.
- tx_ack dropping while in a BEAT state is illegal for the arbiter. The generator ignores it and keeps its outputs.
- cmd_valid arriving while busy waits; cmd_ready stays 0.
- tx_ack already high in the REQ cycle (left over from an earlier grant) is not possible, because REL waits for ack low.

Decomposition:
- Shared package pcie_tlp_pkg holds:
  - FMT_3DW_DATA=2'b10, FMT_4DW_DATA=2'b11, TYPE_MEM=5'b00000.
  - State encoding IDLE/REQ/BEAT0/BEAT1/BEAT2/REL.
  - Function build_mwr_hdr(...) returning H0/H1.
- No sub-module; a single FSM plus a datapath register.

Test Plan:
- addr=0x0000_0000_1234_5678, data=0xDEADBEEF, id=0x0100, tready=1, ack one cycle after req:
  - beat0 = {0x0100_00_0F, 0x4000_0001}.
  - beat1 = {0xDEADBEEF, 0x1234_5678}, keep FF, tlast=1.
  - tlp_count=1.
- addr=0x0000_0001_8000_0004: 3 beats; H0=0x6000_0001; beat1={0x8000_0004, 0x0000_0001}; beat2 keep=0x0F, data in [31:0].
- tready held low for 5 cycles at beat1: tdata/tkeep/tlast stable, tvalid=1 throughout; packet completes after tready rises.
- Ack delayed 10 cycles: tvalid stays 0 until ack; cmd_ready=0; second command stalls until REL sees ack=0.
- 257 back-to-back commands: tag sequence 0..255 then 0; tlp_count=257.
- sys_rst_n pulsed low during beat1: next cycle tx_req=0, tvalid=0, cmd_ready=1 after release, tlp_count=0.
